// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch controller between the PC register and a variable-latency
// instruction memory. Issues one request per PC value, holds the returned instruction
// until the core consumes it, and stalls the PC meanwhile. Flush discards any held or
// in-flight instruction. A saturating counter tracks stalled cycles.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   current_pc       PC register output
//   fetch_stall      1 = PC register must hold
//   imem_req_*       request channel (valid/ready/addr)
//   imem_resp_*      response channel (single-cycle valid pulse, data)
//   flush            discard current fetch and restart from current_pc
//   inst_valid/ready held instruction handshake towards the core
//   inst, inst_pc    held instruction and the address it came from
//   stall_count      saturating count of cycles with fetch_stall = 1
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current_pc,
  output logic              fetch_stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] req_pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [CNT_W-1:0]  stall_count_q;

  logic req_fire;
  logic resp_keep;

  assign req_fire  = (state_q == StReq) && imem_req_ready;
  // A response is only kept when it lands in WAIT and no flush is pending.
  assign resp_keep = (state_q == StWait) && imem_resp_valid && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (req_fire) begin
          state_d = flush ? StDrain : StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          state_d = flush ? StReq : StHold;
        end else if (flush) begin
          // Response still owed by memory; it must be absorbed before re-requesting.
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      StHold: begin
        if (flush || inst_ready) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_req_addr  = (state_q == StReq) ? current_pc : '0;
    inst_valid     = (state_q == StHold);
    // Flush beats a simultaneous consume so the PC does not advance past a dropped word.
    fetch_stall    = !((state_q == StHold) && inst_ready && !flush);
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    stall_count    = stall_count_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q      <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      stall_count_q <= '0;
    end else begin
      if (req_fire) begin
        req_pc_q <= current_pc;
      end
      if (resp_keep) begin
        inst_q    <= imem_resp_data;
        inst_pc_q <= req_pc_q;
      end
      if (fetch_stall && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A default build and a CNT_W = 4 build share
// all inputs; the narrow build exercises stall counter saturation.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        flush;
  logic        inst_ready;

  logic        fetch_stall, imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst, inst_pc, stall_count;

  logic        fetch_stall4, imem_req_valid4, inst_valid4;
  logic [31:0] imem_req_addr4, inst4, inst_pc4;
  logic [3:0]  stall_count4;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .current_pc      (current_pc),
    .fetch_stall     (fetch_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .flush           (flush),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .stall_count     (stall_count)
  );

  instr_fetch_unit #(.CNT_W(4)) dut4 (
    .clk             (clk),
    .reset           (reset),
    .current_pc      (current_pc),
    .fetch_stall     (fetch_stall4),
    .imem_req_valid  (imem_req_valid4),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr4),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .flush           (flush),
    .inst_valid      (inst_valid4),
    .inst_ready      (inst_ready),
    .inst            (inst4),
    .inst_pc         (inst_pc4),
    .stall_count     (stall_count4)
  );

  initial forever #5 clk = ~clk;

  // PC register: holds while stalled, otherwise advances by one word.
  always @(posedge clk) begin
    if (reset) current_pc <= 32'h0;
    else if (!fetch_stall) current_pc <= current_pc + 32'd4;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; flush = 1'b0; inst_ready = 1'b0;
    step(); step(); #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_addr", imem_req_addr, 0);
    check("rst_count", stall_count, 0);
    check("rst_stall", fetch_stall, 1);

    // cycle 0: IDLE
    reset = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; #1;
    check("c0_req_valid", imem_req_valid, 0);
    check("c0_stall", fetch_stall, 1);
    step(); #1; // cycle 1: first request
    check("c1_req_valid", imem_req_valid, 1);
    check("c1_addr", imem_req_addr, 0);
    check("c1_count", stall_count, 1);
    check("c1_stall", fetch_stall, 1);
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013; #1; // cycle 2: WAIT
    check("c2_req_valid", imem_req_valid, 0);
    check("c2_inst_valid", inst_valid, 0);
    check("c2_count", stall_count, 2);
    step(); imem_resp_valid = 1'b0; #1; // cycle 3: HOLD, consumed
    check("c3_inst_valid", inst_valid, 1);
    check("c3_inst", inst, 32'h0000_0013);
    check("c3_inst_pc", inst_pc, 0);
    check("c3_stall", fetch_stall, 0);
    check("c3_count", stall_count, 3);
    step(); #1; // cycle 4: second request
    check("c4_req_valid", imem_req_valid, 1);
    check("c4_addr", imem_req_addr, 4);
    check("c4_count", stall_count, 3);
    check("c4_inst_valid", inst_valid, 0);
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; #1; // cycle 5
    step(); imem_resp_valid = 1'b0; inst_ready = 1'b0; #1; // cycle 6: HOLD, core busy
    check("c6_inst", inst, 32'h0010_0093);
    check("c6_inst_pc", inst_pc, 4);
    check("c6_count", stall_count, 5);
    for (int i = 0; i < 3; i++) begin
      check("hold_inst_valid", inst_valid, 1);
      check("hold_inst", inst, 32'h0010_0093);
      check("hold_inst_pc", inst_pc, 4);
      check("hold_stall", fetch_stall, 1);
      check("hold_no_req", imem_req_valid, 0);
      step(); #1;
    end
    inst_ready = 1'b1; #1; // cycle 9
    check("c9_stall", fetch_stall, 0);
    check("c9_count", stall_count, 8);

    step(); imem_req_ready = 1'b0; #1; // cycle 10: memory not ready for 4 cycles
    check("c10_count", stall_count, 8);
    for (int i = 0; i < 4; i++) begin
      check("bp_req_valid", imem_req_valid, 1);
      check("bp_addr", imem_req_addr, 8);
      check("bp_stall", fetch_stall, 1);
      step(); #1;
    end
    imem_req_ready = 1'b1; #1; // cycle 14
    check("c14_req_valid", imem_req_valid, 1);
    check("c14_addr", imem_req_addr, 8);
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_0001; #1; // cycle 15
    step(); imem_resp_valid = 1'b0; #1; // cycle 16
    check("c16_inst", inst, 32'hAAAA_0001);
    check("c16_inst_pc", inst_pc, 8);
    check("c16_stall", fetch_stall, 0);
    check("c16_count", stall_count, 14);
    check("c16_count4", stall_count4, 14);

    step(); #1; // cycle 17: request accepted
    check("c17_req_valid", imem_req_valid, 1);
    check("c17_addr", imem_req_addr, 12);
    step(); flush = 1'b1; #1; // cycle 18: WAIT + flush
    check("c18_stall", fetch_stall, 1);
    step(); flush = 1'b0; #1; // cycle 19: DRAIN
    check("c19_req_valid", imem_req_valid, 0);
    check("c19_inst_valid", inst_valid, 0);
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_DEAD; flush = 1'b1; #1; // 20
    check("c20_inst_valid", inst_valid, 0);
    step(); imem_resp_valid = 1'b0; imem_req_ready = 1'b0; #1; // 21: REQ, flush w/o handshake
    check("c21_req_valid", imem_req_valid, 1);
    check("c21_addr", imem_req_addr, 12);
    check("c21_inst_valid", inst_valid, 0);
    check("c21_inst_kept", inst, 32'hAAAA_0001);
    step(); flush = 1'b0; imem_req_ready = 1'b1; #1; // cycle 22
    check("c22_req_valid", imem_req_valid, 1);
    check("c22_addr", imem_req_addr, 12);
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'hBBBB_0002; #1; // cycle 23
    step(); imem_resp_valid = 1'b0; flush = 1'b1; inst_ready = 1'b1; #1; // 24: HOLD
    check("c24_inst_valid", inst_valid, 1);
    check("c24_stall", fetch_stall, 1);
    step(); flush = 1'b0; #1; // cycle 25: re-request same PC
    check("c25_inst_valid", inst_valid, 0);
    check("c25_req_valid", imem_req_valid, 1);
    check("c25_addr", imem_req_addr, 12);
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'hCCCC_0003; flush = 1'b1; #1; // 26
    step(); imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678; flush = 1'b0;
    imem_req_ready = 1'b0; #1; // cycle 27: REQ, stray response
    check("c27_req_valid", imem_req_valid, 1);
    check("c27_addr", imem_req_addr, 12);
    check("c27_inst_valid", inst_valid, 0);
    check("c27_inst", inst, 32'hBBBB_0002);
    check("c27_count", stall_count, 24);
    check("c27_count4", stall_count4, 15);
    step(); imem_resp_valid = 1'b0; #1; // cycle 28
    check("c28_req_valid", imem_req_valid, 1);
    check("c28_inst_valid", inst_valid, 0);
    check("c28_inst", inst, 32'hBBBB_0002);
    repeat (19) step();
    imem_req_ready = 1'b1; #1; // cycle 47: after 20 back-pressured cycles
    check("c47_count", stall_count, 44);
    check("c47_count4_sat", stall_count4, 15);
    check("c47_req_valid", imem_req_valid, 1);
    check("c47_addr", imem_req_addr, 12);
    check("c47_stall4", fetch_stall4, 1);
    check("c47_req_valid4", imem_req_valid4, 1);
    check("c47_addr4", imem_req_addr4, 12);
    check("c47_inst_valid4", inst_valid4, 0);
    check("c47_inst4", inst4, 32'hBBBB_0002);
    check("c47_inst_pc4", inst_pc4, 12);

    step(); reset = 1'b1; #1; // cycle 48: WAIT, reset asserted
    check("c48_req_valid", imem_req_valid, 0);
    step(); reset = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0099; #1; // 49
    check("mr_req_valid", imem_req_valid, 0);
    check("mr_inst_valid", inst_valid, 0);
    check("mr_inst", inst, 0);
    check("mr_inst_pc", inst_pc, 0);
    check("mr_addr", imem_req_addr, 0);
    check("mr_count", stall_count, 0);
    check("mr_count4", stall_count4, 0);
    check("mr_stall", fetch_stall, 1);
    step(); imem_req_ready = 1'b0; #1; // cycle 50: REQ, late response again
    check("c50_req_valid", imem_req_valid, 1);
    check("c50_addr", imem_req_addr, 0);
    check("c50_inst_valid", inst_valid, 0);
    check("c50_count", stall_count, 1);
    step(); imem_resp_valid = 1'b0; #1; // cycle 51
    check("c51_req_valid", imem_req_valid, 1);
    check("c51_inst_valid", inst_valid, 0);
    check("c51_inst", inst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
